// File: rtl/regfile_pkg.sv
// Shared register-file constants and the register-index type.
package regfile_pkg;

  localparam int XLEN_DEF = 64;  // default XLEN
  localparam int NREG_DEF = 32;  // default NREG
  localparam int IDX_W    = $clog2(NREG_DEF);
  localparam int CNT_W    = $clog2(NREG_DEF + 1);

  typedef logic [IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t X0_IDX = reg_idx_t'(0);
  localparam reg_idx_t A0_IDX = reg_idx_t'(10);

endpackage

// File: rtl/regfile_if.sv
// Register-file port bundle: writeback, issue, decode reads and status outputs.
interface regfile_if #(
  parameter int XLEN = regfile_pkg::XLEN_DEF
);
  import regfile_pkg::*;

  logic                rf_wen_i;
  reg_idx_t            rf_rd_i;
  logic [XLEN-1:0]     rf_wdata_i;
  reg_idx_t            rs1_i;
  reg_idx_t            rs2_i;
  logic [XLEN-1:0]     rs1_data_o;
  logic [XLEN-1:0]     rs2_data_o;
  logic                iss_valid_i;
  reg_idx_t            iss_rd_i;
  logic                hazard_o;
  logic [CNT_W-1:0]    pending_o;
  logic [XLEN-1:0]     a0_o;

  modport master (
    output rf_wen_i, rf_rd_i, rf_wdata_i, rs1_i, rs2_i, iss_valid_i, iss_rd_i,
    input  rs1_data_o, rs2_data_o, hazard_o, pending_o, a0_o
  );

  modport slave (
    input  rf_wen_i, rf_rd_i, rf_wdata_i, rs1_i, rs2_i, iss_valid_i, iss_rd_i,
    output rs1_data_o, rs2_data_o, hazard_o, pending_o, a0_o
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: RAW hazard flag (combinational) and registered busy count.
// RF_BYPASS_EN: a same-cycle writeback to a source masks that source's hazard.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid_i,
  input  reg_idx_t         iss_rd_i,
  input  logic             wb_wen_i,
  input  reg_idx_t         wb_rd_i,
  input  reg_idx_t         rs1_i,
  input  reg_idx_t         rs2_i,
  output logic             hazard_o,
  output logic [CNT_W-1:0] pending_o
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             wb_act;
  logic             haz1, haz2;

  assign wb_act = wb_wen_i && (wb_rd_i != X0_IDX);

  always_comb begin
    busy_d = busy_q;
    if (wb_act) busy_d[wb_rd_i] = 1'b0;
    // set applied after clear so a same-cycle issue keeps the register busy
    if (iss_valid_i && (iss_rd_i != X0_IDX)) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pending_d = '0;
    for (int i = 1; i < NREG; i++) begin
      pending_d = pending_d + CNT_W'(busy_d[i]);
    end
  end

  always_comb begin
    haz1 = (rs1_i != X0_IDX) && busy_q[rs1_i];
    haz2 = (rs2_i != X0_IDX) && busy_q[rs2_i];
`ifdef RF_BYPASS_EN
    if (wb_act && (wb_rd_i == rs1_i)) haz1 = 1'b0;
    if (wb_act && (wb_rd_i == rs2_i)) haz2 = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign hazard_o  = haz1 || haz2;
  assign pending_o = pending_q;

endmodule

// File: rtl/regfile.sv
// Integer register file, 1 write / 2 combinational read ports, x0 hardwired to zero.
// RF_BYPASS_EN: forward same-cycle writeback data onto the read ports.
module regfile
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic             wr_act;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             hazard;
  logic [CNT_W-1:0] pending;

  assign wr_act = bus.rf_wen_i && (bus.rf_rd_i != X0_IDX);

  always_comb begin
    regs_d = regs_q;
    if (wr_act) regs_d[bus.rf_rd_i] = bus.rf_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data = (bus.rs1_i == X0_IDX) ? '0 : regs_q[bus.rs1_i];
    rs2_data = (bus.rs2_i == X0_IDX) ? '0 : regs_q[bus.rs2_i];
`ifdef RF_BYPASS_EN
    if (wr_act && (bus.rf_rd_i == bus.rs1_i)) rs1_data = bus.rf_wdata_i;
    if (wr_act && (bus.rf_rd_i == bus.rs2_i)) rs2_data = bus.rf_wdata_i;
`endif
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (bus.iss_valid_i),
    .iss_rd_i    (bus.iss_rd_i),
    .wb_wen_i    (bus.rf_wen_i),
    .wb_rd_i     (bus.rf_rd_i),
    .rs1_i       (bus.rs1_i),
    .rs2_i       (bus.rs2_i),
    .hazard_o    (hazard),
    .pending_o   (pending)
  );

  assign bus.rs1_data_o = rs1_data;
  assign bus.rs2_data_o = rs2_data;
  assign bus.hazard_o   = hazard;
  assign bus.pending_o  = pending;
  // architectural a0 only, never the bypassed write data
  assign bus.a0_o       = regs_q[A0_IDX];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed scenarios plus a randomised run against a reference model.
module tb_regfile;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_if #(.XLEN(64)) bus();

  regfile #(.XLEN(64), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  task automatic idle();
    bus.rf_wen_i    = 1'b0;
    bus.rf_rd_i     = '0;
    bus.rf_wdata_i  = '0;
    bus.iss_valid_i = 1'b0;
    bus.iss_rd_i    = '0;
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd5; bus.rf_wdata_i = '1;
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd5;
    tick(); tick();
    rst = 1'b0;
    idle();
    bus.rs1_i = 5'd5; bus.rs2_i = 5'd10;
    mid();
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    e = exp_q.pop_front(); checks++; if (bus.rs1_data_o !== e) begin errors++; $display("FAIL reset_rs1: got %0h expected %0h", bus.rs1_data_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.rs2_data_o !== e) begin errors++; $display("FAIL reset_rs2: got %0h expected %0h", bus.rs2_data_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.a0_o !== e) begin errors++; $display("FAIL reset_a0: got %0h expected %0h", bus.a0_o, e); end
    e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL reset_hazard: got %0h expected %0h", bus.hazard_o, e); end
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL reset_pending: got %0d expected %0d", bus.pending_o, e); end
    tick();
  endtask

  task automatic test_write_read();
    idle();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd5; bus.rf_wdata_i = 64'h1234;
    tick();
    idle();
    bus.rs1_i = 5'd5;
    mid();
    exp_q.push_back(64'h1234); exp_q.push_back(64'h0);
    e = exp_q.pop_front(); checks++; if (bus.rs1_data_o !== e) begin errors++; $display("FAIL wr_rd_rs1: got %0h expected %0h", bus.rs1_data_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.a0_o !== e) begin errors++; $display("FAIL wr_rd_a0: got %0h expected %0h", bus.a0_o, e); end
    tick();
  endtask

  task automatic test_x0();
    idle();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd0; bus.rf_wdata_i = 64'hFFFF;
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd0;
    tick();
    idle();
    mid();
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    e = exp_q.pop_front(); checks++; if (bus.rs1_data_o !== e) begin errors++; $display("FAIL x0_read: got %0h expected %0h", bus.rs1_data_o, e); end
    e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL x0_hazard: got %0h expected %0h", bus.hazard_o, e); end
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL x0_pending: got %0d expected %0d", bus.pending_o, e); end
    tick();
  endtask

  task automatic test_hazard();
    idle();
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd7;
    tick();
    idle();
    bus.rs2_i = 5'd7;
    mid();
    exp_q.push_back(64'h1); exp_q.push_back(64'h1);
    e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL haz_busy: got %0h expected %0h", bus.hazard_o, e); end
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL haz_pending: got %0d expected %0d", bus.pending_o, e); end
    tick();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd7; bus.rf_wdata_i = 64'hAB;
    mid();
`ifdef RF_BYPASS_EN
    exp_q.push_back(64'h0); exp_q.push_back(64'hAB);
`else
    exp_q.push_back(64'h1); exp_q.push_back(64'h0);
`endif
    e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL haz_wb_cycle: got %0h expected %0h", bus.hazard_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.rs2_data_o !== e) begin errors++; $display("FAIL haz_wb_data: got %0h expected %0h", bus.rs2_data_o, e); end
    tick();
    idle();
    bus.rs2_i = 5'd7;
    mid();
    exp_q.push_back(64'h0); exp_q.push_back(64'hAB); exp_q.push_back(64'h0);
    e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL haz_after: got %0h expected %0h", bus.hazard_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.rs2_data_o !== e) begin errors++; $display("FAIL haz_after_data: got %0h expected %0h", bus.rs2_data_o, e); end
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL haz_after_pending: got %0d expected %0d", bus.pending_o, e); end
    tick();
  endtask

  task automatic test_set_wins();
    idle();
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd3;
    tick();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd3; bus.rf_wdata_i = 64'h33;
    tick();
    idle();
    bus.rs1_i = 5'd3;
    mid();
    exp_q.push_back(64'h1); exp_q.push_back(64'h1); exp_q.push_back(64'h33);
    e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL setwins_hazard: got %0h expected %0h", bus.hazard_o, e); end
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL setwins_pending: got %0d expected %0d", bus.pending_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.rs1_data_o !== e) begin errors++; $display("FAIL setwins_data: got %0h expected %0h", bus.rs1_data_o, e); end
    tick();
    idle();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd3; bus.rf_wdata_i = 64'h33;
    tick();
    idle();
  endtask

  task automatic test_a0_idle_clear();
    idle();
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd4;
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd10; bus.rf_wdata_i = 64'h2A;
    tick();
    idle();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd9; bus.rf_wdata_i = 64'h99;
    tick();
    idle();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd10; bus.rf_wdata_i = 64'h55;
    bus.rs1_i = 5'd9;
    mid();
    exp_q.push_back(64'h2A); exp_q.push_back(64'h1); exp_q.push_back(64'h99);
    e = exp_q.pop_front(); checks++; if (bus.a0_o !== e) begin errors++; $display("FAIL a0_no_bypass: got %0h expected %0h", bus.a0_o, e); end
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL idle_clear_pending: got %0d expected %0d", bus.pending_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.rs1_data_o !== e) begin errors++; $display("FAIL idle_clear_data: got %0h expected %0h", bus.rs1_data_o, e); end
    tick();
    idle();
    bus.rf_wen_i = 1'b1; bus.rf_rd_i = 5'd4; bus.rf_wdata_i = 64'h4;
    mid();
    exp_q.push_back(64'h55);
    e = exp_q.pop_front(); checks++; if (bus.a0_o !== e) begin errors++; $display("FAIL a0_updated: got %0h expected %0h", bus.a0_o, e); end
    tick();
    idle();
    mid();
    exp_q.push_back(64'h0);
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL clear_pending: got %0d expected %0d", bus.pending_o, e); end
    tick();
  endtask

  task automatic test_issue_all_reset();
    for (int i = 1; i <= 20; i++) begin
      idle();
      bus.iss_valid_i = 1'b1; bus.iss_rd_i = reg_idx_t'(i);
      mid();
      exp_q.push_back(64'(i - 1));
      e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL issue_pending[%0d]: got %0d expected %0d", i, bus.pending_o, e); end
      tick();
    end
    rst = 1'b1;
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd21;
    tick();
    rst = 1'b0;
    idle();
    bus.rs1_i = 5'd10; bus.rs2_i = 5'd5;
    mid();
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL midrst_pending: got %0d expected %0d", bus.pending_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.rs1_data_o !== e) begin errors++; $display("FAIL midrst_rs1: got %0h expected %0h", bus.rs1_data_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.rs2_data_o !== e) begin errors++; $display("FAIL midrst_rs2: got %0h expected %0h", bus.rs2_data_o, e); end
    e = exp_q.pop_front(); checks++; if (bus.a0_o !== e) begin errors++; $display("FAIL midrst_a0: got %0h expected %0h", bus.a0_o, e); end
    e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL midrst_hazard: got %0h expected %0h", bus.hazard_o, e); end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] regs_m [32];
    logic [31:0] busy_m;
    logic [63:0] r1, r2;
    logic        h1, h2;
    int          pend_m;
    for (int i = 0; i < 32; i++) regs_m[i] = '0;
    busy_m = '0;
    pend_m = 0;
    for (int n = 0; n < 300; n++) begin
      idle();
      bus.rf_wen_i    = ($urandom % 2) == 0;
      bus.rf_rd_i     = reg_idx_t'($urandom % 32);
      bus.rf_wdata_i  = {$urandom, $urandom};
      bus.iss_valid_i = ($urandom % 3) == 0;
      bus.iss_rd_i    = reg_idx_t'($urandom % 32);
      bus.rs1_i       = (($urandom % 4) == 0) ? bus.rf_rd_i : reg_idx_t'($urandom % 32);
      bus.rs2_i       = (($urandom % 4) == 0) ? bus.rf_rd_i : reg_idx_t'($urandom % 32);
      r1 = (bus.rs1_i == 0) ? 64'h0 : regs_m[bus.rs1_i];
      r2 = (bus.rs2_i == 0) ? 64'h0 : regs_m[bus.rs2_i];
      h1 = (bus.rs1_i != 0) && busy_m[bus.rs1_i];
      h2 = (bus.rs2_i != 0) && busy_m[bus.rs2_i];
`ifdef RF_BYPASS_EN
      if (bus.rf_wen_i && bus.rf_rd_i != 0 && bus.rf_rd_i == bus.rs1_i) begin r1 = bus.rf_wdata_i; h1 = 1'b0; end
      if (bus.rf_wen_i && bus.rf_rd_i != 0 && bus.rf_rd_i == bus.rs2_i) begin r2 = bus.rf_wdata_i; h2 = 1'b0; end
`endif
      exp_q.push_back(r1); exp_q.push_back(r2); exp_q.push_back({63'b0, h1 | h2});
      exp_q.push_back(64'(pend_m)); exp_q.push_back(regs_m[10]);
      mid();
      e = exp_q.pop_front(); checks++; if (bus.rs1_data_o !== e) begin errors++; $display("FAIL rnd_rs1 @%0d: got %0h expected %0h", n, bus.rs1_data_o, e); end
      e = exp_q.pop_front(); checks++; if (bus.rs2_data_o !== e) begin errors++; $display("FAIL rnd_rs2 @%0d: got %0h expected %0h", n, bus.rs2_data_o, e); end
      e = exp_q.pop_front(); checks++; if ({63'b0, bus.hazard_o} !== e) begin errors++; $display("FAIL rnd_hazard @%0d: got %0h expected %0h", n, bus.hazard_o, e); end
      e = exp_q.pop_front(); checks++; if ({58'b0, bus.pending_o} !== e) begin errors++; $display("FAIL rnd_pending @%0d: got %0d expected %0d", n, bus.pending_o, e); end
      e = exp_q.pop_front(); checks++; if (bus.a0_o !== e) begin errors++; $display("FAIL rnd_a0 @%0d: got %0h expected %0h", n, bus.a0_o, e); end
      if (bus.rf_wen_i && bus.rf_rd_i != 0) begin
        regs_m[bus.rf_rd_i] = bus.rf_wdata_i;
        busy_m[bus.rf_rd_i] = 1'b0;
      end
      if (bus.iss_valid_i && bus.iss_rd_i != 0) busy_m[bus.iss_rd_i] = 1'b1;
      pend_m = $countones(busy_m[31:1]);
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_x0();
    test_hazard();
    test_set_wins();
    test_a0_idle_clear();
    test_issue_all_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning the register data width in bits.
REQ-002 The module SHALL have parameter NREG, default 32, meaning the number of architectural registers; the index width is log2(NREG), which is 5 at the default.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port rf_wen_i, input, 1 bit: write enable from the writeback stage.
REQ-006 The module SHALL have port rf_rd_i, input, 5 bits: write register index.
REQ-007 The module SHALL have port rf_wdata_i, input, XLEN bits: write data.
REQ-008 The module SHALL have ports rs1_i and rs2_i, input, 5 bits each: decode-stage read indices.
REQ-009 The module SHALL have ports rs1_data_o and rs2_data_o, output, XLEN bits each: read data.
REQ-010 The module SHALL have port iss_valid_i, input, 1 bit: an instruction that writes iss_rd_i issues this cycle.
REQ-011 The module SHALL have port iss_rd_i, input, 5 bits: destination of the issuing instruction.
REQ-012 The module SHALL have port hazard_o, output, 1 bit: rs1_i or rs2_i names a register with a write still pending.
REQ-013 The module SHALL have port pending_o, output, 6 bits: count of busy registers.
REQ-014 The module SHALL have port a0_o, output, XLEN bits: stored value of x10, for the exit/trap report.

Function
REQ-015 Register x0 SHALL read as zero at all times.
- Writes to x0 are discarded.
- Issues to x0 do not set a busy bit.
REQ-016 When rf_wen_i=1, rf_rd_i!=0 and rst=0, reg[rf_rd_i] SHALL take rf_wdata_i at the next rising edge.
REQ-017 Reads SHALL be combinational: rsN_data_o = reg[rsN_i], with x0 returning zero.
REQ-018 Busy bits:
- iss_valid_i=1 with iss_rd_i!=0 sets busy[iss_rd_i] at the next edge.
- rf_wen_i=1 with rf_rd_i!=0 clears busy[rf_rd_i] at the next edge.
REQ-019 If a set and a clear target the same index in the same cycle, the set SHALL win and busy stays 1.
REQ-020 hazard_o SHALL be 1 when (rs1_i!=0 and busy[rs1_i]) or (rs2_i!=0 and busy[rs2_i]).
- The value is evaluated combinationally from the current busy state.
- A same-cycle writeback clears the hazard only when RF_BYPASS_EN is defined (see REQ-026).
REQ-021 pending_o SHALL equal the population count of busy[31:1], registered, updated every cycle from the next-state busy vector; it ranges 0..31.
REQ-022 A clear for a register whose busy bit is 0 SHALL be ignored: no underflow and no error.
REQ-023 a0_o SHALL reflect the stored reg[10] only, never bypassed data.

Reset
REQ-024 While rst=1 at a rising edge:
- all registers and all busy bits become 0;
- pending_o becomes 0;
- writes and issues presented in that cycle are discarded.
REQ-025 After reset, rs1_data_o, rs2_data_o and a0_o SHALL read 0, and hazard_o SHALL be 0.

Configuration
REQ-026 The macro RF_BYPASS_EN SHALL control write-to-read bypass.
- Defined: when rf_wen_i=1, rf_rd_i!=0 and rf_rd_i==rsN_i, rsN_data_o SHALL be rf_wdata_i in the same cycle, and that source SHALL not contribute to hazard_o.
- Undefined: read data shows the write only from the next cycle, and hazard_o follows the stored busy bit.

Structure
REQ-027 The shared package SHALL hold XLEN, NREG, the index-width constant, the x0 and a0 index constants (0, 10) and the reg-index typedef.
REQ-028 One sub-module, rf_scoreboard, SHALL hold the busy vector, the hazard logic and the pending counter.
- The data array and the read/bypass muxes remain in regfile.

Verification
REQ-029 Reset, then write x5=0x1234 and read rs1=5 the next cycle -> rs1_data_o=0x1234 and a0_o=0.
REQ-030 Write x0=0xFFFF and issue x0 -> rs1_i=0 reads 0, hazard_o=0 and pending_o=0.
REQ-031 Issue x7, then set rs2_i=7 -> hazard_o=1 and pending_o=1; writeback x7=0xAB with rs2_i=7 in the same cycle:
- with RF_BYPASS_EN: rs2_data_o=0xAB and hazard_o=0 in that cycle;
- without RF_BYPASS_EN: hazard_o=1 in that cycle and 0 the next cycle.
REQ-032 Busy x3, then issue x3 and write back x3 in the same cycle -> busy[3] stays 1 and pending_o stays 1.
REQ-033 Write x10=0x2A, then a clear of an idle x9 -> a0_o=0x2A and pending_o is unchanged.
REQ-034 Issue x1..x31 on consecutive cycles, then assert rst mid-sequence -> pending_o=0, all reads 0 and hazard_o=0 on the next cycle.
